restoring_divider_n: RTL and testbench
======================================

RESTORING_DIVIDER_N -- requirements
Module: restoring_divider_n

Interface
REQ-001 SHALL provide parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL provide ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start_valid  input  1  request valid.
- start_ready  output  1  block idle, can accept.
- signed_mode  input  1  1 = two's-complement operands.
- dividend  input  WIDTH  dividend.
- divisor  input  WIDTH  divisor.
- done_valid  output  1  result valid.
- done_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  divisor was zero.
REQ-003 SHALL use one clock; reset synchronous, active-high.

Function
REQ-004 SHALL accept a request on a rising edge with start_valid=1 and start_ready=1, capturing dividend, divisor and signed_mode; inputs are ignored at all other times.
REQ-005 SHALL assert start_ready only in IDLE.
REQ-006 SHALL implement FSM IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
REQ-007 PREP (1 cycle): form unsigned magnitudes (negate negative operands when signed_mode=1), record quotient sign = sign XOR and remainder sign = dividend sign; clear partial remainder and iteration counter.
REQ-008 CALC (exactly WIDTH cycles): per cycle, shift {partial remainder, dividend magnitude} left 1; trial-subtract divisor magnitude from the (WIDTH+1)-bit partial remainder; no borrow (carry_out=1) -> keep difference, quotient bit 1; borrow -> restore, quotient bit 0.
REQ-009 FIX (1 cycle): negate quotient and/or remainder per recorded signs; register outputs.
REQ-010 SHALL assert done_valid exactly WIDTH+2 edges after the accepting edge for nonzero divisor.
REQ-011 DONE: hold done_valid, quotient, remainder, div_by_zero stable until an edge with done_ready=1, then return to IDLE; start_ready rises the following cycle (no same-cycle re-accept).
REQ-012 Divide-by-zero: detected in PREP; go PREP -> DONE directly (done_valid 2 edges after accept); quotient = all ones, remainder = captured dividend, div_by_zero=1. Otherwise div_by_zero=0.
REQ-013 Signed overflow (dividend = most-negative, divisor = -1, signed_mode=1): quotient = most-negative, remainder = 0, no flag; SHALL fall out of the magnitude algorithm without special case.
REQ-014 Results satisfy dividend = quotient*divisor + remainder (mod 2^WIDTH), |remainder| < |divisor|, remainder sign = dividend sign (or zero).
REQ-015 start_valid during PREP/CALC/FIX/DONE SHALL have no effect.

Reset
REQ-016 rst=1 at any edge SHALL force IDLE, start_ready=1, done_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0, abandoning any in-flight operation with no result emitted.
REQ-017 rst SHALL take priority over start_valid and done_ready on the same edge.

Structure
REQ-018 Shared package SHALL hold FSM state encoding (5 states) and the counter-width function clog2(WIDTH+1).
REQ-019 Trial subtraction SHALL be one sub-module addsub_n (parameter N = WIDTH+1; ports src1, src2, sub_flag, sum, carry_out; carry-lookahead, sub_flag inverts src2 and injects carry-in 1), instantiated once with sub_flag tied 1.
REQ-020 Only the CALC datapath register set SHALL update per iteration; no combinational path from start_valid to done_valid.

Verification (WIDTH=32)
REQ-021 Unsigned 100/7, done_ready=1 -> done_valid at edge 34 after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-022 Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-023 Divisor=0, dividend=0x12345678 (both modes) -> done_valid at edge 2, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-025 done_ready held 0 for 10 cycles -> outputs stable, start_ready=0, second start_valid ignored; release -> IDLE, next request accepted one cycle later.
REQ-026 rst pulsed at CALC iteration 10 -> next cycle start_ready=1, done_valid=0, outputs 0; subsequent 100/7 completes correctly.

Source files
------------

// File: rtl/restoring_divider_n_pkg.sv
// -----------------------------------------------------------------------------
// restoring_divider_n_pkg
//   Shared definitions for the restoring divider:
//   - state_t   : five-state controller encoding
//   - cnt_width : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package restoring_divider_n_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    // Counter must hold 0..width, hence clog2(width + 1).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/addsub_n.sv
// -----------------------------------------------------------------------------
// addsub_n
//   N-bit carry-lookahead adder/subtractor (parallel-prefix carry tree).
//   Ports:
//     src1, src2 : operands
//     sub_flag   : 1 = src1 - src2 (src2 inverted, carry-in 1), 0 = src1 + src2
//     sum        : N-bit result
//     carry_out  : carry out of the top bit (for subtraction: 1 = no borrow)
// -----------------------------------------------------------------------------
module addsub_n #(
    parameter int N = 33
) (
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic         sub_flag,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    logic [N-1:0] op2;
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    assign op2  = src2 ^ {N{sub_flag}};
    assign gen  = src1 & op2;
    assign prop = src1 ^ op2;

    // Kogge-Stone prefix: after the loop, grp_g[i]/grp_p[i] describe bits i..0
    // as one group, so every carry is a two-level function of the carry-in.
    // NOTE: every variable assigned in always_comb gets a value on every pass
    // before it is read; otherwise a latch would be inferred.
    always_comb begin : prefix_tree
        logic [N-1:0] grp_g;
        logic [N-1:0] grp_p;
        logic [N-1:0] nxt_g;
        logic [N-1:0] nxt_p;
        grp_g = gen;
        grp_p = prop;
        for (int span = 1; span < N; span = span * 2) begin
            nxt_g = grp_g;
            nxt_p = grp_p;
            for (int i = span; i < N; i++) begin
                nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-span]);
                nxt_p[i] = grp_p[i] & grp_p[i-span];
            end
            grp_g = nxt_g;
            grp_p = nxt_p;
        end
        carry[0] = sub_flag;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = grp_g[i] | (grp_p[i] & sub_flag);
        end
    end

    assign sum       = prop ^ carry[N-1:0];
    assign carry_out = carry[N];

endmodule

// File: rtl/restoring_divider_n.sv
// -----------------------------------------------------------------------------
// restoring_divider_n
//   Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle.
//   Sequence: IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE;
//   a zero divisor goes PREP -> DONE directly.
//   Ports:
//     clk, rst                  : clock (rising edge), synchronous active-high reset
//     start_valid / start_ready : request handshake (ready only in IDLE)
//     signed_mode               : 1 = two's-complement operands
//     dividend, divisor         : operands, captured on the accepting edge
//     done_valid / done_ready   : result handshake, result held until accepted
//     quotient, remainder       : registered results
//     div_by_zero               : divisor was zero (quotient = all ones,
//                                 remainder = dividend)
// -----------------------------------------------------------------------------
module restoring_divider_n
    import restoring_divider_n_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;

    // Captured request
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic             signed_r;

    // Iteration datapath
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] dq;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_mag;
    logic             q_neg;
    logic             r_neg;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             keep;
    logic             accept;

    assign accept  = start_valid & start_ready;
    assign dvd_neg = signed_r & dividend_r[WIDTH-1];
    assign dvs_neg = signed_r & divisor_r[WIDTH-1];

    // {partial remainder, next dividend bit} as a (WIDTH+1)-bit trial value.
    assign shifted = {rem, dq[WIDTH-1]};

    addsub_n #(
        .N(WIDTH + 1)
    ) u_trial_sub (
        .src1      (shifted),
        .src2      ({1'b0, dvs_mag}),
        .sub_flag  (1'b1),
        .sum       (diff),
        .carry_out (no_borrow)
    );

    // shifted < 2*divisor, so a borrow-free difference is always below the
    // divisor and its top bit is clear; folding it in keeps the full sum used.
    assign keep = no_borrow & ~diff[WIDTH];

    // Controller and result registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_PREP;
                        start_ready <= 1'b0;
                    end
                end
                ST_PREP: begin
                    cnt <= '0;
                    if (divisor_r == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend_r;
                        div_by_zero <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient    <= q_neg ? -dq : dq;
                    remainder   <= r_neg ? -rem : rem;
                    div_by_zero <= 1'b0;
                    done_valid  <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    // Zero-divisor path arrives with done_valid still low and
                    // raises it here, one edge after PREP.
                    if (!done_valid) begin
                        done_valid <= 1'b1;
                    end else if (done_ready) begin
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    start_ready <= 1'b1;
                    done_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Operand and iteration registers.
    // NOTE: these carry no reset; they are always loaded before being read,
    // and the controller reset alone guarantees no stale result is emitted.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    dividend_r <= dividend;
                    divisor_r  <= divisor;
                    signed_r   <= signed_mode;
                end
            end
            ST_PREP: begin
                dq      <= dvd_neg ? -dividend_r : dividend_r;
                dvs_mag <= dvs_neg ? -divisor_r : divisor_r;
                rem     <= '0;
                q_neg   <= dvd_neg ^ dvs_neg;
                r_neg   <= dvd_neg;
            end
            ST_CALC: begin
                rem <= keep ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                dq  <= {dq[WIDTH-2:0], keep};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_restoring_divider_n.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider_n
//   Directed self-checking bench for restoring_divider_n at WIDTH = 32.
// -----------------------------------------------------------------------------
module tb_restoring_divider_n;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    restoring_divider_n #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, count edges from the accepting edge to done_valid,
    // then check latency and results. Operand inputs are scrambled after the
    // accept to show they are not sampled again.
    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] dd,
                          input logic [W-1:0] dv, input int exp_lat,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input logic exp_z);
        int n;
        check({tag, " ready_before"}, 64'(start_ready), 64'd1);
        signed_mode = sm;
        dividend    = dd;
        divisor     = dv;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        signed_mode = ~sm;
        check({tag, " ready_busy"}, 64'(start_ready), 64'd0);
        n = 0;
        while (!done_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " quotient"}, 64'(quotient), 64'(exp_q));
        check({tag, " remainder"}, 64'(remainder), 64'(exp_r));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_z));
        @(posedge clk);
        #1;
        check({tag, " done_released"}, 64'(done_valid), 64'd0);
        check({tag, " ready_after"}, 64'(start_ready), 64'd1);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        start_valid = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        done_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst start_ready", 64'(start_ready), 64'd1);
        check("rst done_valid", 64'(done_valid), 64'd0);
        check("rst quotient", 64'(quotient), 64'd0);
        check("rst remainder", 64'(remainder), 64'd0);
        check("rst div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic unsigned and signed division
        run_op("u100/7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
        run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'd14, 32'hFFFF_FFFE, 1'b0);
        run_op("uFFFFFFFF/16", 1'b0, 32'hFFFF_FFFF, 32'd16, 34, 32'h0FFF_FFFF, 32'hF, 1'b0);
        run_op("uFFFFFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("u5/9", 1'b0, 32'd5, 32'd9, 34, 32'd0, 32'd5, 1'b0);

        // Divide by zero, both modes
        run_op("u_div0", 1'b0, 32'h1234_5678, 32'd0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_op("s_div0", 1'b1, 32'h1234_5678, 32'd0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

        // Most-negative by -1
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0);
        run_op("u_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 1'b0);

        // Back-pressure: result held while done_ready is low
        done_ready  = 1'b0;
        signed_mode = 1'b0;
        dividend    = 32'd1000;
        divisor     = 32'd3;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        n = 0;
        while (!done_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall latency", 64'(n), 64'd34);
        dividend    = 32'd5;
        divisor     = 32'd1;
        start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall done_valid", 64'(done_valid), 64'd1);
            check("stall quotient", 64'(quotient), 64'd333);
            check("stall remainder", 64'(remainder), 64'd1);
            check("stall start_ready", 64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("release done_valid", 64'(done_valid), 64'd0);
        check("release start_ready", 64'(start_ready), 64'd1);
        run_op("after_stall 100/7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);

        // Reset in the middle of CALC
        signed_mode = 1'b0;
        dividend    = 32'd100;
        divisor     = 32'd7;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid busy", 64'(start_ready), 64'd0);
        rst = 1'b1;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_valid = 1'b0;
        check("midrst start_ready", 64'(start_ready), 64'd1);
        check("midrst done_valid", 64'(done_valid), 64'd0);
        check("midrst quotient", 64'(quotient), 64'd0);
        check("midrst remainder", 64'(remainder), 64'd0);
        check("midrst div_by_zero", 64'(div_by_zero), 64'd0);
        run_op("after_rst 100/7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
